keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// - Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 matrix keypad.
// - Drives one column at a time and reads the rows, then debounces the press and the release.
// - Emits one key event per press.
// - Keeps a 3-digit entry register (u, d, c) in the 5-bit display code, so it wires straight into the display driver.
// PARAMETERS
// - SCAN_DIV  default 1000  clk cycles per scan step (column settle + sample period), >=2
// - DEBOUNCE  default 8     consecutive stable samples to accept a press / release, >=2
// - BLANK     default 5'd17 display code for an empty digit
// PORTS
// - clk        in   1  system clock, all logic on posedge
// - rst_n      in   1  synchronous, active-low reset
// - rows       in   4  keypad rows, pulled up, active-low, asynchronous
// - cols       out  4  keypad column drive, active-low, exactly one bit low
// - key_code   out  4  code of the last accepted key
// - key_valid  out  1  one-cycle pulse per accepted press
// - enter      out  1  one-cycle pulse, coincident with key_valid, when the key is '#'
// - u, d, c    out  5  entered digits: units, tens, hundreds (0-9 or BLANK)
// BEHAVIOUR
// - Reset (rst_n=0 at a posedge):
//   - state=SCAN, col_idx=0, cols=4'b1110, div=0, deb=0.
//   - Row synchronizer = 4'hF, key_code=0, key_valid=0, enter=0, u=d=c=BLANK.
// - Synchronizer and tick:
//   - rows pass through a 2-FF synchronizer (rows_s); the FSM only ever looks at rows_s.
//   - div counts 0..SCAN_DIV-1 and wraps; tick = (div==SCAN_DIV-1).
//   - The FSM acts on tick only, except PRESSED, which lasts exactly 1 cycle.
//   - div is cleared on every column change.
// - Column drive: cols = ~(4'b0001 << col_idx). Advancing means col_idx+1, wrapping 3->0.
// - Key map (row r, col k), codes:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: * 0 # D
//   - Codes: digit = its value; A..D = 10..13; '*' = 14; '#' = 15.
// - FSM:
//   - SCAN: on tick, if rows_s != 4'hF:
//     - Latch row = lowest-index low bit (simultaneous keys in one column -> lowest row wins).
//     - deb=0, hold the column, go to DBNC.
//     - Otherwise advance the column.
//   - DBNC: on tick, if rows_s[row]==0 then deb++.
//     - Go to PRESSED when deb reaches DEBOUNCE-1.
//     - If rows_s[row]==1, this is a glitch: advance the column and go to SCAN; no event.
//   - PRESSED (1 cycle):
//     - key_valid=1; key_code=map(row, col_idx).
//     - Digit update below; deb=0; go to REL.
//   - REL: on tick, if rows_s[row]==1 then deb++, else deb=0.
//     - When deb reaches DEBOUNCE-1: advance the column, go to SCAN.
//     - Keys in other columns are ignored while in REL (no rollover).
// - Digit update, in the PRESSED cycle, visible the next cycle:
//   - Code 0-9: c<=d, d<=u, u<={1'b0,code}. The oldest digit is discarded; there is no overflow flag.
//   - Code 14: u=d=c=BLANK.
//   - Code 15: enter=1 for this cycle; digits unchanged.
//   - Codes 10-13: key_valid only, digits unchanged.
// - Outputs:
//   - key_valid and enter are registered and high for exactly 1 cycle.
//   - key_code holds its value until the next event.
// - Latency, press stable -> key_valid: at most (4+DEBOUNCE)*SCAN_DIV + 3 cycles (includes the 2-FF sync).
// - A key held indefinitely produces exactly one event; there is no auto-repeat.
// - Reset mid-operation: the state, digits and outputs above are restored on the next posedge, whatever the FSM state.
// TESTING (SCAN_DIV=4, DEBOUNCE=3, keypad model shorts col k to row r)
// - Reset: rst_n=0 for 2 cycles -> cols=1110, u=d=c=17, key_valid=0, enter=0.
//   - Idle: cols steps 1110->1101->1011->0111->1110 every 4 cycles.
// - Press '5' (r1,k1) held for 200 cycles:
//   - Exactly one key_valid pulse, key_code=5, u=5, d=17, c=17.
//   - No second event until release is seen and a new press occurs.
// - Press 1, 2, 3, 4 in sequence (each with a clean release) -> after the last: c=2, d=3, u=4.
// - Press '#' -> key_valid and enter high in the same single cycle, key_code=15, digits unchanged.
//   - Then press '*' -> u=d=c=17, enter stays 0.
// - Bounce: a row low for 1 tick then high -> no key_valid, scan resumes at the next column.
//   - Release bounce inside REL (high 1 tick, low 1 tick, then stable high) -> still one event.
// - Two keys, '4' and '7', in column 0 pressed together -> key_code=4.
//   - Assert rst_n=0 during DBNC -> all outputs at reset values, no event.

Source files
------------

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. Debounces both
// the press and the release, and emits exactly one key event per press. Keeps
// a 3-digit entry register in the 5-bit display code, so u/d/c can feed the
// 7-segment display driver directly.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   rows[3:0]  in   keypad rows, pulled up, active-low, asynchronous
//   cols[3:0]  out  column drive, active-low, exactly one bit low
//   key_code   out  code of the last accepted key (held until the next event)
//   key_valid  out  one-cycle pulse per accepted press
//   enter      out  one-cycle pulse with key_valid when the key is '#'
//   u, d, c    out  units / tens / hundreds digit (0-9 or BLANK)
//
// state   | meaning
// SCAN    | stepping columns, waiting for any row low
// DBNC    | column held, counting stable-low samples of the latched row
// PRESSED | single cycle: emit event, update digits
// REL     | column held, counting stable-high samples of the latched row
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int         SCAN_DIV = 1000,
    parameter int         DEBOUNCE = 8,
    parameter logic [4:0] BLANK    = 5'd17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       enter,
    output logic [4:0] u,
    output logic [4:0] d,
    output logic [4:0] c
);

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] DBNC    = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] REL     = 2'd3;

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // deb is compared before its increment, so DEBOUNCE-2 here means the
    // counter reaches DEBOUNCE-1 on this tick.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 2);

    logic [1:0]       state;
    logic [1:0]       col_idx;
    logic [1:0]       row;
    logic [DIV_W-1:0] div;
    logic [DEB_W-1:0] deb;
    logic [3:0]       rows_m;
    logic [3:0]       rows_s;
    logic             tick;
    logic [1:0]       low_row;
    logic [3:0]       cur_code;

    assign tick = (div == DIV_LAST);
    assign cols = ~(4'b0001 << col_idx);

    // Lowest-index low row wins when several keys in a column are down.
    always_comb begin
        low_row = 2'd3;
        if (!rows_s[2]) low_row = 2'd2;
        if (!rows_s[1]) low_row = 2'd1;
        if (!rows_s[0]) low_row = 2'd0;
    end

    always_comb begin
        cur_code = 4'd0;
        case ({row, col_idx})
            4'b00_00: cur_code = 4'd1;
            4'b00_01: cur_code = 4'd2;
            4'b00_10: cur_code = 4'd3;
            4'b00_11: cur_code = 4'd10;
            4'b01_00: cur_code = 4'd4;
            4'b01_01: cur_code = 4'd5;
            4'b01_10: cur_code = 4'd6;
            4'b01_11: cur_code = 4'd11;
            4'b10_00: cur_code = 4'd7;
            4'b10_01: cur_code = 4'd8;
            4'b10_10: cur_code = 4'd9;
            4'b10_11: cur_code = 4'd12;
            4'b11_00: cur_code = 4'd14;
            4'b11_01: cur_code = 4'd0;
            4'b11_10: cur_code = 4'd15;
            4'b11_11: cur_code = 4'd13;
            default:  cur_code = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row       <= 2'd0;
            div       <= '0;
            deb       <= '0;
            rows_m    <= 4'hF;
            rows_s    <= 4'hF;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            enter     <= 1'b0;
            u         <= BLANK;
            d         <= BLANK;
            c         <= BLANK;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            enter     <= 1'b0;
            div       <= tick ? '0 : div + 1'b1;

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (rows_s != 4'hF) begin
                            row   <= low_row;
                            deb   <= '0;
                            state <= DBNC;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            div     <= '0;
                        end
                    end
                end
                DBNC: begin
                    if (tick) begin
                        if (!rows_s[row]) begin
                            deb <= deb + 1'b1;
                            if (deb == DEB_LAST) state <= PRESSED;
                        end else begin
                            // Glitch: drop it and move on without an event.
                            col_idx <= col_idx + 2'd1;
                            div     <= '0;
                            state   <= SCAN;
                        end
                    end
                end
                PRESSED: begin
                    key_valid <= 1'b1;
                    key_code  <= cur_code;
                    if (cur_code <= 4'd9) begin
                        c <= d;
                        d <= u;
                        u <= {1'b0, cur_code};
                    end else if (cur_code == 4'd14) begin
                        u <= BLANK;
                        d <= BLANK;
                        c <= BLANK;
                    end else if (cur_code == 4'd15) begin
                        enter <= 1'b1;
                    end
                    deb   <= '0;
                    state <= REL;
                end
                REL: begin
                    // Column stays held, so other keys are invisible here.
                    if (tick) begin
                        if (rows_s[row]) begin
                            deb <= deb + 1'b1;
                            if (deb == DEB_LAST) begin
                                col_idx <= col_idx + 2'd1;
                                div     <= '0;
                                deb     <= '0;
                                state   <= SCAN;
                            end
                        end else begin
                            deb <= '0;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       enter;
    logic [4:0] u, d, c;

    logic [15:0] key_down;   // bit r*4+k: key at row r, column k held down
    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;
    int en_cnt = 0;
    int en_alone = 0;
    logic [3:0] last_code = 4'd0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .BLANK(5'd17)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .enter     (enter),
        .u         (u),
        .d         (d),
        .c         (c)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key shorts its column to its row.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (key_down[r*4+k] && !cols[k]) rows[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            ev_cnt    <= ev_cnt + 1;
            last_code <= key_code;
        end
        if (enter) begin
            en_cnt <= en_cnt + 1;
            if (!key_valid) en_alone <= en_alone + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input int eu, input int ed, input int ec);
        chk({tag, "_u"}, 32'(u), 32'(eu));
        chk({tag, "_d"}, 32'(d), 32'(ed));
        chk({tag, "_c"}, 32'(c), 32'(ec));
    endtask

    // Press key (r,k), wait for its event, hold, release, let release settle.
    task automatic press_key(input int r, input int k, input int hold);
        int e0;
        int n;
        e0 = ev_cnt;
        key_down[r*4+k] = 1'b1;
        n = 0;
        while (ev_cnt == e0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (ev_cnt == e0) chk("press_timeout", 32'(ev_cnt - e0), 32'd1);
        repeat (hold) @(negedge clk);
        key_down = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (cols != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (cols != target) chk("wait_col_timeout", 32'(cols), 32'(target));
    endtask

    initial begin
        int e0;
        logic [3:0] exp_cols [4];
        exp_cols[0] = 4'b1101;
        exp_cols[1] = 4'b1011;
        exp_cols[2] = 4'b0111;
        exp_cols[3] = 4'b1110;

        key_down = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cols", 32'(cols), 32'hE);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_enter", 32'(enter), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk_digits("rst", 17, 17, 17);
        rst_n = 1'b1;

        // Idle scan: one column step every 4 cycles.
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            chk("idle_cols", 32'(cols), 32'(exp_cols[i]));
        end

        // '5' held for a long time: exactly one event.
        e0 = ev_cnt;
        press_key(1, 1, 200);
        chk("hold5_events", 32'(ev_cnt - e0), 32'd1);
        chk("hold5_code", 32'(last_code), 32'd5);
        chk("hold5_keycode_held", 32'(key_code), 32'd5);
        chk_digits("hold5", 5, 17, 17);

        // 1, 2, 3, 4 in sequence.
        e0 = ev_cnt;
        press_key(0, 0, 10);
        press_key(0, 1, 10);
        press_key(0, 2, 10);
        press_key(1, 0, 10);
        chk("seq_events", 32'(ev_cnt - e0), 32'd4);
        chk("seq_code", 32'(last_code), 32'd4);
        chk_digits("seq", 4, 3, 2);

        // '#': enter with key_valid, digits kept.
        press_key(3, 2, 10);
        chk("hash_code", 32'(last_code), 32'd15);
        chk("hash_enter_cnt", 32'(en_cnt), 32'd1);
        chk("hash_enter_alone", 32'(en_alone), 32'd0);
        chk_digits("hash", 4, 3, 2);

        // '*': clear, no enter.
        press_key(3, 0, 10);
        chk("star_code", 32'(last_code), 32'd14);
        chk("star_enter_cnt", 32'(en_cnt), 32'd1);
        chk_digits("star", 17, 17, 17);

        // Press glitch on '8' (row 2, column 1): low for one tick only.
        e0 = ev_cnt;
        wait_col(4'b1101);
        key_down[2*4+1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_col_held", 32'(cols), 32'b1101);
        key_down = '0;
        repeat (4) @(negedge clk);
        chk("glitch_next_col", 32'(cols), 32'b1011);
        repeat (40) @(negedge clk);
        chk("glitch_events", 32'(ev_cnt - e0), 32'd0);

        // Release bounce on '6' (row 1, column 2).
        e0 = ev_cnt;
        key_down[1*4+2] = 1'b1;
        begin
            int n;
            n = 0;
            while (ev_cnt == e0 && n < 80) begin
                @(negedge clk);
                n++;
            end
        end
        key_down = '0;
        repeat (4) @(negedge clk);
        key_down[1*4+2] = 1'b1;
        repeat (4) @(negedge clk);
        key_down = '0;
        repeat (60) @(negedge clk);
        chk("relbounce_events", 32'(ev_cnt - e0), 32'd1);
        chk("relbounce_code", 32'(last_code), 32'd6);
        chk_digits("relbounce", 6, 17, 17);

        // '4' and '7' together in column 0: lower row wins.
        e0 = ev_cnt;
        key_down[1*4+0] = 1'b1;
        key_down[2*4+0] = 1'b1;
        press_key(1, 0, 10);
        chk("two_keys_events", 32'(ev_cnt - e0), 32'd1);
        chk("two_keys_code", 32'(last_code), 32'd4);
        chk_digits("two_keys", 4, 6, 17);

        // Reset while debouncing '1'.
        e0 = ev_cnt;
        wait_col(4'b1110);
        key_down[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("dbnc_col_held", 32'(cols), 32'b1110);
        rst_n = 1'b0;
        key_down = '0;
        repeat (2) @(negedge clk);
        chk("midrst_cols", 32'(cols), 32'hE);
        chk("midrst_code", 32'(key_code), 32'd0);
        chk("midrst_kv", 32'(key_valid), 32'd0);
        chk_digits("midrst", 17, 17, 17);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_events", 32'(ev_cnt - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
